// File: rtl/fifo_rd_stream_adapter.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream: rden at N gives a word at N+2, then 1 word/cycle.
// Reads are issued only while buffered plus in-flight words stay below two, so any amount of m_ready backpressure is absorbed without loss.
module fifo_rd_stream_adapter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rden,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  words_out
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              occ_q, occ_d;
    logic              inflight_q;
    logic              valid_q;
    logic [DATA_W-1:0] slot0_q, slot0_d;
    logic [DATA_W-1:0] slot1_q, slot1_d;
    logic [CNT_W-1:0]  words_q;

    logic       pop;
    logic       arrive;
    logic [2:0] pending;

    assign pop    = valid_q && m_ready;
    assign arrive = inflight_q;

    // Words that will occupy the buffer once the in-flight read lands, net of this cycle's pop.
    assign pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rden = !rst && !fifo_empty && (pending < 3'd2);

    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (occ_q)
            EMPTY: begin
                if (arrive) begin
                    slot0_d = fifo_rdata;
                    occ_d   = ONE;
                end
            end
            ONE: begin
                if (arrive && pop) begin
                    slot0_d = fifo_rdata;
                end else if (arrive) begin
                    slot1_d = fifo_rdata;
                    occ_d   = TWO;
                end else if (pop) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    occ_d   = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            words_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rden;
            valid_q    <= (occ_d != EMPTY);
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            words_q    <= words_q + CNT_W'(pop);
        end
    end

    assign m_valid   = valid_q;
    assign m_data    = slot0_q;
    assign words_out = words_q;

endmodule
